// File: rtl/match_controller.sv
// Match sequencing for a two-player ball game: serve delay, point awarding,
// win detection and the control pulses sent to the score display.
module match_controller #(
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_DELAY = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic ball_out_left,
  input  logic ball_out_right,
  output logic player_left_scores,
  output logic player_right_scores,
  output logic score_clear,
  output logic ball_enable,
  output logic serve,
  output logic serve_left,
  output logic game_over,
  output logic winner_left
);

  // state      | meaning
  // IDLE       | after reset, waiting for a start edge
  // SERVE_WAIT | delay counter running down before the serve
  // PLAY       | ball in motion, goal lines watched
  // POINT      | one cycle: score pulse out, counter bump, win check
  // GAME_OVER  | match decided, waiting for a start edge
  typedef enum logic [2:0] {IDLE, SERVE_WAIT, PLAY, POINT, GAME_OVER} state_t;

  localparam logic [25:0] DELAY_LOAD = 26'(SERVE_DELAY - 1);
  localparam logic [7:0]  WIN_TARGET = 8'(WIN_SCORE);

  state_t      state, state_next;
  logic        start_q, start_edge;
  logic [25:0] delay, delay_next;
  logic [6:0]  cnt_left, cnt_right, cnt_left_next, cnt_right_next;
  logic [7:0]  scorer_plus1;
  logic        scorer_wins;
  logic        left_scores_next, right_scores_next, score_clear_next;
  logic        ball_enable_next, serve_next, serve_left_next;
  logic        game_over_next, winner_left_next;

  assign start_edge = start & ~start_q;

  // In POINT the registered score pulse identifies which side just scored.
  assign scorer_plus1 = player_left_scores ? ({1'b0, cnt_left} + 8'd1)
                                           : ({1'b0, cnt_right} + 8'd1);
  assign scorer_wins  = (scorer_plus1 == WIN_TARGET);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      start_q             <= 1'b0;
      delay               <= '0;
      cnt_left            <= '0;
      cnt_right           <= '0;
      player_left_scores  <= 1'b0;
      player_right_scores <= 1'b0;
      score_clear         <= 1'b0;
      ball_enable         <= 1'b0;
      serve               <= 1'b0;
      serve_left          <= 1'b0;
      game_over           <= 1'b0;
      winner_left         <= 1'b0;
    end else begin
      state               <= state_next;
      start_q             <= start;
      delay               <= delay_next;
      cnt_left            <= cnt_left_next;
      cnt_right           <= cnt_right_next;
      player_left_scores  <= left_scores_next;
      player_right_scores <= right_scores_next;
      score_clear         <= score_clear_next;
      ball_enable         <= ball_enable_next;
      serve               <= serve_next;
      serve_left          <= serve_left_next;
      game_over           <= game_over_next;
      winner_left         <= winner_left_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, GAME_OVER: if (start_edge) state_next = SERVE_WAIT;
      SERVE_WAIT:      if (delay == '0) state_next = PLAY;
      PLAY: begin
        if (ball_out_left && ball_out_right)      state_next = SERVE_WAIT;
        else if (ball_out_left || ball_out_right) state_next = POINT;
      end
      POINT:           state_next = scorer_wins ? GAME_OVER : SERVE_WAIT;
      default:         state_next = IDLE;
    endcase
  end

  always_comb begin
    delay_next        = delay;
    cnt_left_next     = cnt_left;
    cnt_right_next    = cnt_right;
    left_scores_next  = 1'b0;
    right_scores_next = 1'b0;
    score_clear_next  = 1'b0;
    serve_next        = 1'b0;
    ball_enable_next  = (state_next == PLAY);
    game_over_next    = (state_next == GAME_OVER);
    serve_left_next   = serve_left;
    winner_left_next  = winner_left;
    case (state)
      IDLE, GAME_OVER: begin
        if (start_edge) begin
          cnt_left_next    = '0;
          cnt_right_next   = '0;
          score_clear_next = 1'b1;
          delay_next       = DELAY_LOAD;
        end
      end
      SERVE_WAIT: begin
        if (delay != '0) delay_next = delay - 26'd1;
        else             serve_next = 1'b1;
      end
      PLAY: begin
        // Both lines crossed at once is a void rally: re-serve, same direction.
        if (ball_out_left && ball_out_right) delay_next        = DELAY_LOAD;
        else if (ball_out_right)             left_scores_next  = 1'b1;
        else if (ball_out_left)              right_scores_next = 1'b1;
      end
      POINT: begin
        if (player_left_scores)
          cnt_left_next = (cnt_left == 7'd127) ? cnt_left : cnt_left + 7'd1;
        else
          cnt_right_next = (cnt_right == 7'd127) ? cnt_right : cnt_right + 7'd1;
        serve_left_next = player_right_scores;
        if (scorer_wins) winner_left_next = player_left_scores;
        else             delay_next       = DELAY_LOAD;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 The block SHALL have parameter WIN_SCORE, default 11, meaning the points needed to win a match (legal range 1..99).
REQ-002 The block SHALL have parameter SERVE_DELAY, default 50000000, meaning the number of clk cycles spent in SERVE_WAIT before each serve (legal range 1..2^26-1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: start button level, already synchronous to clk.
REQ-006 The block SHALL have port ball_out_left, input, 1 bit: level, ball has crossed the left goal line.
REQ-007 The block SHALL have port ball_out_right, input, 1 bit: level, ball has crossed the right goal line.
REQ-008 The block SHALL have port player_left_scores, output, 1 bit: one-cycle point pulse to the score display block.
REQ-009 The block SHALL have port player_right_scores, output, 1 bit: one-cycle point pulse to the score display block.
REQ-010 The block SHALL have port score_clear, output, 1 bit: one-cycle pulse that clears the score display counters.
REQ-011 The block SHALL have port ball_enable, output, 1 bit: ball motion is permitted.
REQ-012 The block SHALL have port serve, output, 1 bit: one-cycle pulse that launches the ball from centre.
REQ-013 The block SHALL have port serve_left, output, 1 bit: serve direction, 1 = toward the left player.
REQ-014 The block SHALL have port game_over, output, 1 bit: match finished.
REQ-015 The block SHALL have port winner_left, output, 1 bit: valid while game_over; 1 = left player won.

Function
REQ-016 The FSM SHALL have states IDLE, SERVE_WAIT, PLAY, POINT and GAME_OVER, and all outputs SHALL be registered.
REQ-017 A start rising edge SHALL be detected as start high while the previous-cycle start register is low.
REQ-018 In IDLE or GAME_OVER, a start rising edge SHALL clear both internal 7-bit score counters, assert score_clear for exactly 1 cycle, load the delay counter with SERVE_DELAY-1 and enter SERVE_WAIT.
REQ-019 SERVE_WAIT SHALL:
- decrement the delay counter each cycle;
- at count 0, enter PLAY with serve=1 for exactly the first PLAY cycle;
- last exactly SERVE_DELAY cycles.
REQ-020 ball_enable SHALL be 1 in every PLAY cycle and 0 in all other states.
REQ-021 In PLAY, ball_out_right=1 alone SHALL award a point to left, and ball_out_left=1 alone SHALL award a point to right; either SHALL enter POINT on the next edge.
REQ-022 In PLAY, ball_out_left and ball_out_right both 1 in the same cycle SHALL award no point, re-enter SERVE_WAIT with a reloaded delay, and leave serve_left unchanged.
REQ-023 POINT SHALL last exactly 1 cycle, with exactly one of player_left_scores / player_right_scores high for that cycle.
- This gives 1-cycle latency from the sampled out-of-bounds edge to the pulse.
REQ-024 In POINT, the scorer's counter SHALL increment by 1, saturating at 127.
- serve_left SHALL be set toward the conceding player (1 if right scored).
REQ-025 In POINT, if the scorer's counter+1 == WIN_SCORE, the FSM SHALL enter GAME_OVER and set winner_left to the scorer; otherwise it SHALL load the delay counter and enter SERVE_WAIT.
REQ-026 In GAME_OVER:
- game_over SHALL be 1 and winner_left SHALL be held;
- ball_out inputs SHALL be ignored;
- only a start rising edge SHALL exit (per REQ-018), and game_over SHALL clear on the same edge that enters SERVE_WAIT.
REQ-027 A start edge in SERVE_WAIT, PLAY or POINT SHALL be ignored.
REQ-028 Out-of-bounds inputs outside PLAY SHALL be ignored.
REQ-029 A level held high across several cycles SHALL produce only one point, because PLAY is left on the first cycle.

Reset
REQ-030 While reset_n=0, immediately and independent of clk, the block SHALL hold:
- state IDLE;
- both counters, the delay counter and the start edge register cleared;
- every output 0, including serve_left and winner_left.
REQ-031 Reset asserted mid-match SHALL abandon the match without emitting any pulse.
REQ-032 On release, the block SHALL wait in IDLE for a start rising edge.

Verification (WIN_SCORE=3, SERVE_DELAY=4)
REQ-033 Reset then start 0->1 -> score_clear=1 for 1 cycle; serve=1 exactly 4 cycles after SERVE_WAIT entry; ball_enable=1 from that cycle.
REQ-034 In PLAY, hold ball_out_right=1 for 10 cycles -> exactly one player_left_scores pulse, 1 cycle after first sample; ball_enable=0; serve_left=0; next serve after 4 cycles.
REQ-035 Score left 3 times -> after the third pulse, game_over=1, winner_left=1, ball_enable=0; further ball_out pulses produce no score pulse.
REQ-036 ball_out_left=ball_out_right=1 in the same PLAY cycle -> no score pulse, SERVE_WAIT re-entered, serve after 4 cycles, counters unchanged.
REQ-037 Drop reset_n for 1 cycle in mid-SERVE_WAIT -> all outputs 0 asynchronously; no serve pulse; IDLE until a new start edge.
REQ-038 In GAME_OVER, pulse start -> score_clear pulse; game_over=0; both counters 0; a new match proceeds to win at 3 again.
